// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   N_REQ / ID_W : requester count and encoded-index width
//   state_t      : arbiter FSM states
//   cnt_width()  : hold-counter width derived from MAX_HOLD
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Counter must reach MAX_HOLD-1; MAX_HOLD is legal in 2..255.
  function automatic int unsigned cnt_width(input int unsigned max_hold);
    return (max_hold < 2) ? 1 : $clog2(max_hold);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority encoder.
// Searches (req & mask) starting at index ptr+1, wrapping modulo 4;
// the first set bit wins.
//   req       [3:0] request vector
//   ptr       [1:0] last owner; search starts one past it
//   mask      [3:0] candidates allowed (clear bit = excluded)
//   win_id    [1:0] winning index (0 when none)
//   win_valid       a winner exists
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [ID_W-1:0]  win_id,
  output logic             win_valid
);

  logic [N_REQ-1:0] cand;
  logic [ID_W-1:0]  idx;

  always_comb begin
    cand      = req & mask;
    win_id    = '0;
    win_valid = 1'b0;
    idx       = '0;
    // ID_W-bit addition wraps modulo 4; i==N_REQ lands on ptr itself last.
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = ptr + ID_W'(i);
      if (!win_valid && cand[idx]) begin
        win_id    = idx;
        win_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant.
// A grant is held until its owner drops req; on release the next
// requester (searching from the last owner + 1) is granted on the same
// edge. Optional hold timeout enabled by macro ARB_TIMEOUT_EN forces
// rotation after MAX_HOLD cycles when others are waiting.
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req      [3:0] request vector
//   gnt      [3:0] one-hot grant, zero when idle
//   gnt_id   [1:0] index of current/last owner
//   gnt_valid      a grant is active
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid
);

  state_t           state, state_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [ID_W-1:0]  id_nxt;
  logic             valid_nxt;
  logic [ID_W-1:0]  ptr, ptr_nxt;

  logic [N_REQ-1:0] mask;
  logic [ID_W-1:0]  win_id;
  logic             win_valid;
  logic             owner_req;
  logic             timeout;
  logic             take_win;

  // While granted the owner is excluded, so a timeout picks someone else.
  assign mask      = (state == GRANT) ? ~gnt : '1;
  assign owner_req = |(req & gnt);

  rr_pick4 u_pick (
    .req       (req),
    .ptr       (ptr),
    .mask      (mask),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned      CNT_W   = cnt_width(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             others;

  assign others  = |(req & ~gnt);
  assign timeout = (cnt == CNT_MAX) && others;

  always_comb begin
    cnt_nxt = cnt;
    if (take_win) begin
      cnt_nxt = '0;
    end else if (state == GRANT && owner_req && cnt != CNT_MAX) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    valid_nxt = gnt_valid;
    ptr_nxt   = ptr;
    take_win  = 1'b0;

    unique case (state)
      IDLE: begin
        take_win = win_valid;
      end
      GRANT: begin
        if (owner_req) begin
          take_win = timeout;
        end else if (win_valid) begin
          take_win = 1'b1;
        end else begin
          // gnt_id intentionally keeps the last owner.
          state_nxt = IDLE;
          gnt_nxt   = '0;
          valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (take_win) begin
      state_nxt = GRANT;
      gnt_nxt   = N_REQ'(1) << win_id;
      id_nxt    = win_id;
      valid_nxt = 1'b1;
      ptr_nxt   = win_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      ptr       <= 2'd3;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= id_nxt;
      gnt_valid <= valid_nxt;
      ptr       <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed scenarios with literal
// expectations plus randomized requests against a behavioural model.
module tb_rr_arbiter4;

  localparam int MH = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  int n_pass = 0;
  int n_tot  = 0;
  bit cmp_on = 0;

  rr_arbiter4 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_owner = -1;  // -1 = nobody
  int m_last  = 3;   // last owner, search starts after it
  int m_id    = 0;
  int m_hold  = 0;   // cycles held beyond the grant edge, saturating
  int t_owner, t_last, t_id, t_hold, t_w;

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1; m_last <= 3; m_id <= 0; m_hold <= 0;
    end else begin
      t_owner = m_owner; t_last = m_last; t_id = m_id; t_hold = m_hold;
      t_w = -1;
      if (t_owner < 0) begin
        t_w = pick(req, t_last);
      end else if (req[t_owner]) begin
`ifdef ARB_TIMEOUT_EN
        if (t_hold == MH - 1 && (req & ~(4'b1 << t_owner)) != 0)
          t_w = pick(req & ~(4'b1 << t_owner), t_last);
        else
`endif
          t_hold = (t_hold < MH - 1) ? t_hold + 1 : t_hold;
      end else begin
        t_w = pick(req, t_last);
        if (t_w < 0) t_owner = -1;
      end
      if (t_w >= 0) begin
        t_owner = t_w; t_last = t_w; t_id = t_w; t_hold = 0;
      end
      m_owner <= t_owner; m_last <= t_last; m_id <= t_id; m_hold <= t_hold;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("gnt", gnt, (m_owner < 0) ? 0 : (1 << m_owner));
      check("gnt_id", gnt_id, m_id);
      check("gnt_valid", gnt_valid, m_owner >= 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] id, input logic v);
    check({name, "_gnt"}, gnt, g);
    check({name, "_id"}, gnt_id, id);
    check({name, "_valid"}, gnt_valid, v);
  endtask

  logic [1:0] seq_ids [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] flip;

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    step();
    rst_n  = 1'b1;
    cmp_on = 1;
    expect_out("reset", 4'b0000, 2'd0, 1'b0);

    // Single requester, then asynchronous reset mid-grant.
    req = 4'b0001;
    step();
    expect_out("first_grant", 4'b0001, 2'd0, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 4'b0000, 2'd0, 1'b0);
    do_reset();

    // All requesting, each owner releases after 2 cycles.
    req = 4'b1111;
    step();
    expect_out("rr_start", 4'b0001, 2'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_hold_id", gnt_id, k);
      req = 4'b1111 & ~(4'b0001 << k);
      step();
      check("rr_next_id", gnt_id, seq_ids[k]);
      check("rr_no_idle", gnt_valid, 1'b1);
      req = 4'b1111;
    end
    do_reset();

    // Owner 2, then 0 and 3 arrive; release order 2 -> 3 -> 0.
    req = 4'b0100;
    step();
    check("own2", gnt_id, 2'd2);
    req = 4'b1101;
    step();
    check("own2_kept", gnt_id, 2'd2);
    req = 4'b1001;
    step();
    check("to3", gnt_id, 2'd3);
    req = 4'b0001;
    step();
    expect_out("to0", 4'b0001, 2'd0, 1'b1);
    do_reset();

    // All drop while 1 owns; then 1 alone again.
    req = 4'b0010;
    step();
    check("own1", gnt_id, 2'd1);
    req = 4'b0000;
    step();
    expect_out("idle_keep_id", 4'b0000, 2'd1, 1'b0);
    req = 4'b0010;
    step();
    expect_out("regrant1", 4'b0010, 2'd1, 1'b1);
    do_reset();

    // Long hold by requester 0 with requester 1 waiting.
    req = 4'b0001;
    step();
    req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < MH; i++) begin
      step();
      check("to_hold0", gnt_id, 2'd0);
    end
    step();
    expect_out("to_move1", 4'b0010, 2'd1, 1'b1);
    do_reset();
    req = 4'b0001;
    step();
    for (int i = 0; i < 12; i++) begin
      step();
      check("sat_hold0", gnt, 4'b0001);
    end
`else
    for (int i = 0; i < 20; i++) begin
      step();
      check("nto_hold0", gnt, 4'b0001);
    end
    req = 4'b0010;
    step();
    expect_out("nto_to1", 4'b0010, 2'd1, 1'b1);
`endif
    do_reset();

    // Randomized requests with sticky bits and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      flip = 4'b0000;
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 5) == 0);
      req = req ^ flip;
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rand_async_reset", {gnt_valid, gnt}, 5'b0);
        step();
        rst_n = 1'b1;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
